// File: rtl/fir_pkg.sv
// fir_pkg: shared rounding-mode constants and saturation bounds for the FIR datapath.
// Contents:
//   ROUND_TRUNC / ROUND_HALF_UP / ROUND_CONVERGENT  rounding mode encodings
//   sat_max(w) / sat_min(w)                         two's complement limits of a w-bit value
package fir_pkg;

    localparam int ROUND_TRUNC      = 0;
    localparam int ROUND_HALF_UP    = 1;
    localparam int ROUND_CONVERGENT = 2;

    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/fir_round_stage.sv
// fir_round_stage: drops SHIFT LSBs with the selected rounding mode and registers the result (S1).
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   en                 pipeline advance enable
//   i_data, i_valid    full-precision sample and its valid bit
//   s1_data, s1_valid  registered rounded value (IN_WIDTH+1 bits) and valid
module fir_round_stage
    import fir_pkg::*;
#(
    parameter int IN_WIDTH   = 33,
    parameter int SHIFT      = 15,
    parameter int ROUND_MODE = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       en,
    input  logic signed [IN_WIDTH-1:0] i_data,
    input  logic                       i_valid,
    output logic signed [IN_WIDTH:0]   s1_data,
    output logic                       s1_valid
);

    localparam int W = IN_WIDTH + 1;
    // Half an output LSB; zero when nothing is discarded.
    localparam logic signed [W-1:0] HALF = W'((64'd1 << SHIFT) >> 1);

    logic signed [W-1:0] xe, bias, sum, data_d, data_q;
    logic                valid_d, valid_q;

    always_comb begin
        xe      = {i_data[IN_WIDTH-1], i_data};
        // Convergent: bias is half-1 plus the LSB of the truncated result, so
        // exact halves move only when that LSB is odd.
        bias    = (ROUND_MODE == ROUND_TRUNC || SHIFT == 0) ? '0 :
                  (ROUND_MODE == ROUND_HALF_UP) ? HALF :
                  HALF - W'(1) + W'(xe[SHIFT]);
        sum     = xe + bias;
        data_d  = en ? (sum >>> SHIFT) : data_q;
        valid_d = en ? i_valid : valid_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign s1_data  = data_q;
    assign s1_valid = valid_q;

endmodule

// File: rtl/fir_output_requant.sv
// fir_output_requant: rounds, saturates/wraps and narrows the FIR output stream with overflow tracking.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   i_data, i_valid, i_ready  full-precision input stream
//   o_data, o_valid, o_ready  narrowed output stream
//   o_ovf                     o_data overflowed OUT_WIDTH
//   ovf_count, ovf_clear      saturating overflow counter and its synchronous clear
module fir_output_requant
    import fir_pkg::*;
#(
    parameter int IN_WIDTH   = 33,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 15,
    parameter int ROUND_MODE = 2,
    parameter int SATURATE   = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic signed [IN_WIDTH-1:0] i_data,
    input  logic                       i_valid,
    output logic                       i_ready,
    output logic [OUT_WIDTH-1:0]       o_data,
    output logic                       o_valid,
    input  logic                       o_ready,
    output logic                       o_ovf,
    output logic [CNT_WIDTH-1:0]       ovf_count,
    input  logic                       ovf_clear
);

    if (SHIFT >= IN_WIDTH || OUT_WIDTH < 2 || ROUND_MODE > 2) begin : g_bad_params
        $error("fir_output_requant: illegal SHIFT, OUT_WIDTH or ROUND_MODE");
    end

    localparam int W = IN_WIDTH + 1;
    // Compare in a width wide enough for both the rounded value and the output.
    localparam int M = (W > OUT_WIDTH) ? W : OUT_WIDTH;
    localparam logic signed [M-1:0] MAXV = M'(sat_max(OUT_WIDTH));
    localparam logic signed [M-1:0] MINV = M'(sat_min(OUT_WIDTH));

    logic                 en, s1_valid, ovf;
    logic signed [W-1:0]  s1_data;
    logic signed [M-1:0]  r_ext;
    logic [OUT_WIDTH-1:0] data_d, data_q;
    logic                 ovf_d, ovf_q, valid_d, valid_q;
    logic [CNT_WIDTH-1:0] cnt_d, cnt_q;

    assign en      = !valid_q || o_ready;
    assign i_ready = en;

    fir_round_stage #(
        .IN_WIDTH   (IN_WIDTH),
        .SHIFT      (SHIFT),
        .ROUND_MODE (ROUND_MODE)
    ) u_round (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .i_data   (i_data),
        .i_valid  (i_valid),
        .s1_data  (s1_data),
        .s1_valid (s1_valid)
    );

    always_comb begin
        r_ext   = M'(s1_data);
        ovf     = (r_ext > MAXV) || (r_ext < MINV);
        data_d  = !en ? data_q :
                  (SATURATE != 0 && ovf) ? ((r_ext > MAXV) ? MAXV[OUT_WIDTH-1:0] : MINV[OUT_WIDTH-1:0]) :
                  r_ext[OUT_WIDTH-1:0];
        ovf_d   = en ? ovf : ovf_q;
        valid_d = en ? s1_valid : valid_q;
        // Clear wins over a coincident increment; the count sticks at all-ones.
        cnt_d   = ovf_clear ? '0 :
                  (valid_q && o_ready && ovf_q && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_data    = data_q;
    assign o_ovf     = ovf_q;
    assign o_valid   = valid_q;
    assign ovf_count = cnt_q;

endmodule

// File: tb/tb_fir_output_requant.sv
// tb_fir_output_requant: directed and backpressure bench for four requantizer configurations.
module tb_fir_output_requant;

    typedef struct {
        longint x;
        int     e0, e1, e2, e3;
        bit     o0, o1, o2, o3;
    } vec_t;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               i_valid = 1'b0;
    logic               o_ready = 1'b0;
    logic               ovf_clear = 1'b0;
    logic signed [32:0] i_data = '0;
    logic               i_ready [4];
    logic               o_valid [4];
    logic               o_ovf [4];
    logic [15:0]        o_data [4];
    logic [15:0]        ovf_count [4];
    int                 checks = 0;
    int                 errors = 0;

    always #5 clk = ~clk;

    // Instances 0..2: rounding modes 0..2 with saturation; instance 3: convergent with wrap.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        fir_output_requant #(
            .IN_WIDTH   (33),
            .OUT_WIDTH  (16),
            .SHIFT      (15),
            .ROUND_MODE ((g == 3) ? 2 : g),
            .SATURATE   ((g == 3) ? 0 : 1),
            .CNT_WIDTH  (16)
        ) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .i_data    (i_data),
            .i_valid   (i_valid),
            .i_ready   (i_ready[g]),
            .o_data    (o_data[g]),
            .o_valid   (o_valid[g]),
            .o_ready   (o_ready),
            .o_ovf     (o_ovf[g]),
            .ovf_count (ovf_count[g]),
            .ovf_clear (ovf_clear)
        );
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: floor, remainder, then decide the round-up from the remainder.
    function automatic void model(input longint x, input int g, output longint d, output bit ov);
        longint q, f, r;
        int     mode;
        mode = (g == 3) ? 2 : g;
        q    = x >>> 15;
        f    = x - q * 32768;
        r    = (mode == 0) ? q :
               (mode == 1) ? q + ((f >= 16384) ? 1 : 0) :
               q + ((f > 16384 || (f == 16384 && q[0])) ? 1 : 0);
        ov   = (r > 32767) || (r < -32768);
        d    = (g != 3 && ov) ? ((r > 0) ? 32767 : -32768) : longint'($signed(r[15:0]));
    endfunction

    initial begin
        vec_t   tbl [15];
        int     e [4];
        bit     o [4];
        int     cnt_exp [4];
        int     cm [4];
        longint xs [$];
        longint cur, xv, d;
        bit     ov, acc, stall;
        logic [15:0] pd [4];
        int     sent, got, cyc, w, t;

        tbl[0]  = '{114688,               3,      4,      4,      4,      0, 0, 0, 0};
        tbl[1]  = '{81920,                2,      3,      2,      2,      0, 0, 0, 0};
        tbl[2]  = '{-81920,               -3,     -2,     -2,     -2,     0, 0, 0, 0};
        tbl[3]  = '{-1,                   -1,     0,      0,      0,      0, 0, 0, 0};
        tbl[4]  = '{64'sd4294967295,      32767,  32767,  32767,  0,      1, 1, 1, 1};
        tbl[5]  = '{-64'sd4294967296,     -32768, -32768, -32768, 0,      1, 1, 1, 1};
        tbl[6]  = '{1073741824,           32767,  32767,  32767,  -32768, 1, 1, 1, 1};
        tbl[7]  = '{0,                    0,      0,      0,      0,      0, 0, 0, 0};
        tbl[8]  = '{1073709056,           32767,  32767,  32767,  32767,  0, 0, 0, 0};
        tbl[9]  = '{-1073741824,          -32768, -32768, -32768, -32768, 0, 0, 0, 0};
        tbl[10] = '{1073725440,           32767,  32767,  32767,  -32768, 0, 1, 1, 1};
        tbl[11] = '{49152,                1,      2,      2,      2,      0, 0, 0, 0};
        tbl[12] = '{16384,                0,      1,      0,      0,      0, 0, 0, 0};
        tbl[13] = '{-16384,               -1,     0,      0,      0,      0, 0, 0, 0};
        tbl[14] = '{-49152,               -2,     -1,     -2,     -2,     0, 0, 0, 0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("rst_o_valid[%0d]", g), longint'(o_valid[g]), 0);
            chk($sformatf("rst_o_data[%0d]", g), longint'(o_data[g]), 0);
            chk($sformatf("rst_o_ovf[%0d]", g), longint'(o_ovf[g]), 0);
            chk($sformatf("rst_ovf_count[%0d]", g), longint'(ovf_count[g]), 0);
            chk($sformatf("rst_i_ready[%0d]", g), longint'(i_ready[g]), 1);
            cnt_exp[g] = 0;
        end
        reset_n = 1'b1;
        o_ready = 1'b1;

        // Table: back-to-back stream; output k appears two cycles after it is presented.
        for (int k = 0; k <= 15; k++) begin
            if (k < 15) begin
                i_valid = 1'b1;
                i_data  = tbl[k].x[32:0];
            end else begin
                i_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            for (int g = 0; g < 4; g++)
                chk($sformatf("tbl_valid[%0d] step %0d", g, k), longint'(o_valid[g]), (k >= 1) ? 1 : 0);
            if (k >= 1) begin
                e = '{tbl[k-1].e0, tbl[k-1].e1, tbl[k-1].e2, tbl[k-1].e3};
                o = '{tbl[k-1].o0, tbl[k-1].o1, tbl[k-1].o2, tbl[k-1].o3};
                for (int g = 0; g < 4; g++) begin
                    chk($sformatf("tbl_data[%0d] vec %0d", g, k - 1), longint'($signed(o_data[g])), e[g]);
                    chk($sformatf("tbl_ovf[%0d] vec %0d", g, k - 1), longint'(o_ovf[g]), longint'(o[g]));
                    cnt_exp[g] += int'(o[g]);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("drain_valid[%0d]", g), longint'(o_valid[g]), 0);
            chk($sformatf("tbl_ovf_count[%0d]", g), longint'(ovf_count[g]), cnt_exp[g]);
        end

        // Clear pulse with empty pipeline
        ovf_clear = 1'b1;
        @(posedge clk);
        #1;
        ovf_clear = 1'b0;
        for (int g = 0; g < 4; g++)
            chk($sformatf("clear_count[%0d]", g), longint'(ovf_count[g]), 0);

        // Clear coinciding with an overflowed output transfer
        i_valid = 1'b1;
        i_data  = 33'h0FFFFFFFF;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++)
            chk($sformatf("prio_ovf[%0d]", g), longint'(o_ovf[g] & o_valid[g]), 1);
        ovf_clear = 1'b1;
        @(posedge clk);
        #1;
        ovf_clear = 1'b0;
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("prio_count[%0d]", g), longint'(ovf_count[g]), 0);
            cm[g] = 0;
        end

        // Backpressure: 100 random samples, random o_ready with a 5-cycle hold
        sent  = 0;
        got   = 0;
        cyc   = 0;
        stall = 1'b0;
        cur   = 0;
        while (got < 100 && cyc < 3000) begin
            if (stall)
                for (int g = 0; g < 4; g++) begin
                    chk($sformatf("bp_hold_data[%0d]", g), longint'(o_data[g]), longint'(pd[g]));
                    chk($sformatf("bp_hold_valid[%0d]", g), longint'(o_valid[g]), 1);
                end
            o_ready = (cyc >= 30 && cyc < 35) ? 1'b0 : ($urandom_range(0, 2) != 0);
            if (!i_valid && sent < 100 && $urandom_range(0, 3) != 0) begin
                t       = $urandom;
                cur     = (longint'(t) * 2) >>> $urandom_range(0, 22);
                i_data  = cur[32:0];
                i_valid = 1'b1;
            end
            #1;
            for (int g = 0; g < 4; g++)
                chk($sformatf("bp_i_ready[%0d]", g), longint'(i_ready[g]), longint'(!o_valid[g] || o_ready));
            acc = i_valid && i_ready[0];
            if (acc) begin
                xs.push_back(cur);
                sent++;
            end
            if (o_valid[0] && o_ready) begin
                if (xs.size() == 0) begin
                    chk("bp_spurious_output", 1, 0);
                end else begin
                    xv = xs.pop_front();
                    for (int g = 0; g < 4; g++) begin
                        model(xv, g, d, ov);
                        chk($sformatf("bp_data[%0d] out %0d", g, got), longint'($signed(o_data[g])), d);
                        chk($sformatf("bp_ovf[%0d] out %0d", g, got), longint'(o_ovf[g]), longint'(ov));
                        cm[g] += int'(ov);
                    end
                end
                got++;
            end
            stall = o_valid[0] && !o_ready;
            for (int g = 0; g < 4; g++)
                pd[g] = o_data[g];
            @(posedge clk);
            #1;
            cyc++;
            if (acc)
                i_valid = 1'b0;
        end
        chk("bp_outputs_received", got, 100);
        for (int g = 0; g < 4; g++)
            chk($sformatf("bp_ovf_count[%0d]", g), longint'(ovf_count[g]), cm[g]);

        // Reset with two samples in flight
        o_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = 33'sd81920;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        chk("mid_pre_valid", longint'(o_valid[0]), 1);
        reset_n = 1'b0;
        #1;
        for (int g = 0; g < 4; g++) begin
            chk($sformatf("mid_rst_valid[%0d]", g), longint'(o_valid[g]), 0);
            chk($sformatf("mid_rst_count[%0d]", g), longint'(ovf_count[g]), 0);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        i_valid = 1'b1;
        i_data  = 33'sd114688;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        w = 0;
        while (!o_valid[0] && w < 10) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("post_rst_latency", w, 1);
        e = '{3, 4, 4, 4};
        for (int g = 0; g < 4; g++)
            chk($sformatf("post_rst_data[%0d]", g), longint'($signed(o_data[g])), e[g]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
